// File: rtl/spi_slave_mem.sv
// SPI mode-0 slave fronting a byte memory; SPI pins are oversampled on sclk.
// Opcode CMD_WR streams bytes in, CMD_RD streams bytes out, both auto-increment.
module spi_slave_mem #(
    parameter int          AW     = 8,
    parameter logic [7:0]  CMD_WR = 8'h02,
    parameter logic [7:0]  CMD_RD = 8'h03
) (
    input  logic          sclk,
    input  logic          srstn,
    input  logic          SPI_SCLK,
    input  logic          SPI_CSN,
    input  logic          SPI_MOSI,
    output logic          SPI_MISO,
    output logic          mem_we,
    output logic [AW-1:0] mem_waddr,
    output logic [7:0]    mem_wdata,
    output logic          frame_done,
    output logic          cmd_err,
    input  logic [AW-1:0] dbg_addr,
    output logic [7:0]    dbg_rdata
);

    localparam int DEPTH = 1 << AW;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_WDATA,
        ST_RDATA,
        ST_IGNORE
    } state_e;

    logic [2:0]    sck_q, sck_d;
    logic [2:0]    csn_q, csn_d;
    logic [1:0]    mosi_q, mosi_d;

    state_e        state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [6:0]    rx_sh_q, rx_sh_d;
    logic [7:0]    tx_sh_q, tx_sh_d;
    logic          dir_wr_q, dir_wr_d;
    logic [AW-1:0] addr_ptr_q, addr_ptr_d;
    logic          miso_q, miso_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_waddr_q, mem_waddr_d;
    logic [7:0]    mem_wdata_q, mem_wdata_d;
    logic          frame_done_q, frame_done_d;
    logic          cmd_err_q, cmd_err_d;

    logic [7:0]    mem_q [DEPTH];
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;

    logic          sck_rise, sck_fall, csn_fall, csn_high;
    logic          byte_done, is_wr, is_rd;
    logic [7:0]    rx_byte;
    logic [AW-1:0] byte_addr;

    // Stage 2 is the synced level, stage 3 is history for edge detect.
    always_comb begin
        sck_d  = {sck_q[1:0], SPI_SCLK};
        csn_d  = {csn_q[1:0], SPI_CSN};
        mosi_d = {mosi_q[0], SPI_MOSI};
    end

    assign sck_rise  = sck_q[1] & ~sck_q[2];
    assign sck_fall  = ~sck_q[1] & sck_q[2];
    assign csn_fall  = ~csn_q[1] & csn_q[2];
    assign csn_high  = csn_q[1];
    assign rx_byte   = {rx_sh_q, mosi_q[1]};
    assign byte_done = sck_rise && (bit_cnt_q == 3'd7);
    assign byte_addr = AW'(rx_byte);
    assign is_wr     = (rx_byte == CMD_WR);
    assign is_rd     = (rx_byte == CMD_RD);

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        rx_sh_d      = rx_sh_q;
        tx_sh_d      = tx_sh_q;
        dir_wr_d     = dir_wr_q;
        addr_ptr_d   = addr_ptr_q;
        miso_d       = miso_q;
        mem_we_d     = 1'b0;
        mem_waddr_d  = mem_waddr_q;
        mem_wdata_d  = mem_wdata_q;
        frame_done_d = 1'b0;
        cmd_err_d    = 1'b0;
        wr_en        = 1'b0;
        wr_addr      = addr_ptr_q;
        wr_data      = rx_byte;

        if (state_q == ST_IDLE) begin
            if (csn_fall) begin
                state_d   = ST_CMD;
                bit_cnt_d = 3'd0;
            end
        end else if (csn_high) begin
            state_d      = ST_IDLE;
            bit_cnt_d    = 3'd0;
            miso_d       = 1'b0;
            frame_done_d = 1'b1;
        end else begin
            unique case (state_q)
                ST_CMD, ST_ADDR, ST_WDATA: begin
                    if (sck_rise) begin
                        rx_sh_d   = rx_byte[6:0];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                    if (byte_done) begin
                        unique case (state_q)
                            ST_CMD: begin
                                unique case (1'b1)
                                    is_wr: begin
                                        state_d  = ST_ADDR;
                                        dir_wr_d = 1'b1;
                                    end
                                    is_rd: begin
                                        state_d  = ST_ADDR;
                                        dir_wr_d = 1'b0;
                                    end
                                    default: begin
                                        state_d   = ST_IGNORE;
                                        cmd_err_d = 1'b1;
                                    end
                                endcase
                            end
                            ST_ADDR: begin
                                addr_ptr_d = byte_addr;
                                if (dir_wr_q) begin
                                    state_d = ST_WDATA;
                                end else begin
                                    state_d    = ST_RDATA;
                                    tx_sh_d    = mem_q[byte_addr];
                                    addr_ptr_d = byte_addr + AW'(1);
                                end
                            end
                            default: begin
                                wr_en       = 1'b1;
                                mem_we_d    = 1'b1;
                                mem_waddr_d = addr_ptr_q;
                                mem_wdata_d = rx_byte;
                                addr_ptr_d  = addr_ptr_q + AW'(1);
                            end
                        endcase
                    end
                end
                ST_RDATA: begin
                    if (sck_fall) begin
                        miso_d  = tx_sh_q[7];
                        tx_sh_d = {tx_sh_q[6:0], 1'b0};
                    end
                    if (sck_rise) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        // Reload on the 8th edge so the next byte streams gap-free.
                        if (bit_cnt_q == 3'd7) begin
                            tx_sh_d    = mem_q[addr_ptr_q];
                            addr_ptr_d = addr_ptr_q + AW'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge sclk or negedge srstn) begin
        if (!srstn) begin
            sck_q        <= '0;
            csn_q        <= '0;
            mosi_q       <= '0;
            state_q      <= ST_IDLE;
            bit_cnt_q    <= '0;
            rx_sh_q      <= '0;
            tx_sh_q      <= '0;
            dir_wr_q     <= 1'b0;
            addr_ptr_q   <= '0;
            miso_q       <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_waddr_q  <= '0;
            mem_wdata_q  <= '0;
            frame_done_q <= 1'b0;
            cmd_err_q    <= 1'b0;
        end else begin
            sck_q        <= sck_d;
            csn_q        <= csn_d;
            mosi_q       <= mosi_d;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            rx_sh_q      <= rx_sh_d;
            tx_sh_q      <= tx_sh_d;
            dir_wr_q     <= dir_wr_d;
            addr_ptr_q   <= addr_ptr_d;
            miso_q       <= miso_d;
            mem_we_q     <= mem_we_d;
            mem_waddr_q  <= mem_waddr_d;
            mem_wdata_q  <= mem_wdata_d;
            frame_done_q <= frame_done_d;
            cmd_err_q    <= cmd_err_d;
        end
    end

    always_ff @(posedge sclk or negedge srstn) begin
        if (!srstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign SPI_MISO   = miso_q;
    assign mem_we     = mem_we_q;
    assign mem_waddr  = mem_waddr_q;
    assign mem_wdata  = mem_wdata_q;
    assign frame_done = frame_done_q;
    assign cmd_err    = cmd_err_q;
    assign dbg_rdata  = mem_q[dbg_addr];

endmodule

// File: tb/tb_spi_slave_mem.sv
// Bench for spi_slave_mem: a bit-level SPI master drives byte frames while
// a byte-array memory model and an expected-write queue score the DUT.
module tb_spi_slave_mem;

    logic       clk = 1'b0;
    logic       srstn;
    logic       SPI_SCLK, SPI_CSN, SPI_MOSI;
    logic       SPI_MISO;
    logic       mem_we;
    logic [7:0] mem_waddr, mem_wdata;
    logic       frame_done, cmd_err;
    logic [7:0] dbg_addr, dbg_rdata;

    spi_slave_mem dut (
        .sclk       (clk),
        .srstn      (srstn),
        .SPI_SCLK   (SPI_SCLK),
        .SPI_CSN    (SPI_CSN),
        .SPI_MOSI   (SPI_MOSI),
        .SPI_MISO   (SPI_MISO),
        .mem_we     (mem_we),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata),
        .frame_done (frame_done),
        .cmd_err    (cmd_err),
        .dbg_addr   (dbg_addr),
        .dbg_rdata  (dbg_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int fd_cnt = 0;
    int err_cnt = 0;

    logic [7:0]  mem_m [256];
    logic [15:0] exq [$];
    logic [7:0]  tx_buf [16];
    logic [7:0]  rx_buf [16];
    int          bitpos;
    logic        miso_seen;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Scoreboard for the write-observation port and pulse counters.
    always @(negedge clk) begin
        if (srstn) begin
            if (frame_done) fd_cnt++;
            if (cmd_err) err_cnt++;
            if (mem_we) begin
                if (exq.size() == 0) begin
                    chk("we_unexpected", 1, 0);
                end else begin
                    logic [15:0] e;
                    e = exq.pop_front();
                    chk("waddr", mem_waddr, e[15:8]);
                    chk("wdata", mem_wdata, e[7:0]);
                end
            end
        end
    end

    task automatic fill_rand();
        for (int i = 0; i < 16; i++) begin
            tx_buf[i] = 8'($urandom);
            rx_buf[i] = 8'h00;
        end
    endtask

    task automatic csn_low();
        bitpos    = 0;
        miso_seen = 1'b0;
        for (int i = 0; i < 16; i++) rx_buf[i] = 8'h00;
        SPI_MOSI = tx_buf[0][7];
        SPI_CSN  = 1'b0;
        tick(5);
    endtask

    task automatic bits(input int n);
        logic [3:0] by;
        logic [2:0] bi;
        for (int k = 0; k < n; k++) begin
            by = 4'(bitpos / 8);
            bi = 3'(7 - (bitpos % 8));
            SPI_MOSI = tx_buf[by][bi];
            tick(5);
            rx_buf[by][bi] = SPI_MISO;
            miso_seen = miso_seen | SPI_MISO;
            SPI_SCLK = 1'b1;
            tick(5);
            SPI_SCLK = 1'b0;
            bitpos++;
        end
    endtask

    task automatic csn_rise();
        tick(5);
        SPI_CSN = 1'b1;
        tick(8);
    endtask

    task automatic dbg_chk(input string tag, input logic [7:0] a,
                           input logic [7:0] exp);
        dbg_addr = a;
        #1;
        chk(tag, dbg_rdata, exp);
    endtask

    // Write frame: opcode, address, n data bytes from tx_buf[2..], then a
    // partial byte of `partial` bits that must be dropped.
    task automatic do_write(input logic [7:0] a, input int n,
                            input int partial);
        int fd0, er0;
        logic [7:0] wa;
        tx_buf[0] = 8'h02;
        tx_buf[1] = a;
        for (int k = 0; k < n; k++) begin
            wa = a + 8'(k);
            exq.push_back({wa, tx_buf[2+k]});
            mem_m[wa] = tx_buf[2+k];
        end
        fd0 = fd_cnt;
        er0 = err_cnt;
        csn_low();
        bits(16 + 8 * n + partial);
        csn_rise();
        chk("wr_frame_done", fd_cnt - fd0, 1);
        chk("wr_cmd_err", err_cnt - er0, 0);
        chk("wr_pending", exq.size(), 0);
        chk("wr_miso_idle", miso_seen, 0);
        for (int k = 0; k < n; k++) begin
            wa = a + 8'(k);
            dbg_chk("wr_dbg", wa, mem_m[wa]);
        end
    endtask

    task automatic do_read(input logic [7:0] a, input int n);
        int fd0, er0;
        tx_buf[0] = 8'h03;
        tx_buf[1] = a;
        fd0 = fd_cnt;
        er0 = err_cnt;
        csn_low();
        bits(16 + 8 * n);
        csn_rise();
        chk("rd_hdr_miso", {rx_buf[0], rx_buf[1]}, 0);
        for (int k = 0; k < n; k++) begin
            chk("rd_data", rx_buf[2+k], mem_m[a + 8'(k)]);
        end
        chk("rd_frame_done", fd_cnt - fd0, 1);
        chk("rd_cmd_err", err_cnt - er0, 0);
    endtask

    // Frame that must write nothing and keep MISO low.
    task automatic do_raw(input int nbits, input int exp_err);
        int fd0, er0;
        fd0 = fd_cnt;
        er0 = err_cnt;
        csn_low();
        bits(nbits);
        csn_rise();
        chk("raw_frame_done", fd_cnt - fd0, 1);
        chk("raw_cmd_err", err_cnt - er0, exp_err);
        chk("raw_miso_idle", miso_seen, 0);
    endtask

    initial begin
        logic [7:0] a;
        int         fd0;
        int         kind;

        srstn    = 1'b0;
        SPI_SCLK = 1'b0;
        SPI_CSN  = 1'b1;
        SPI_MOSI = 1'b0;
        dbg_addr = 8'h00;
        for (int i = 0; i < 256; i++) mem_m[i] = 8'h00;
        tick(5);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_cmd_err", cmd_err, 0);
        chk("rst_miso", SPI_MISO, 0);
        chk("rst_waddr", mem_waddr, 0);
        chk("rst_wdata", mem_wdata, 0);
        srstn = 1'b1;
        tick(8);
        dbg_chk("rst_dbg", 8'h55, 8'h00);

        fill_rand();
        tx_buf[2] = 8'hAA;
        tx_buf[3] = 8'hBB;
        tx_buf[4] = 8'hCC;
        do_write(8'h55, 3, 0);
        do_read(8'h55, 3);

        fill_rand();
        tx_buf[2] = 8'h11;
        tx_buf[3] = 8'h22;
        tx_buf[4] = 8'h33;
        do_write(8'hFE, 3, 0);
        dbg_chk("wrap_00", 8'h00, 8'h33);
        do_read(8'hFF, 2);

        fill_rand();
        tx_buf[0] = 8'h9F;
        tx_buf[1] = 8'h00;
        tx_buf[2] = 8'h12;
        do_raw(24, 1);

        fill_rand();
        tx_buf[2] = 8'hA5;
        do_write(8'h10, 1, 4);
        dbg_chk("abort_11", 8'h11, mem_m[8'h11]);
        do_read(8'h10, 1);

        fill_rand();
        do_write(8'h20, 0, 0);

        // Reset in the middle of a data byte with CSN held low.
        fill_rand();
        tx_buf[0] = 8'h02;
        tx_buf[1] = 8'h40;
        csn_low();
        bits(20);
        srstn = 1'b0;
        tick(2);
        chk("mrst_mem_we", mem_we, 0);
        chk("mrst_frame_done", frame_done, 0);
        chk("mrst_cmd_err", cmd_err, 0);
        chk("mrst_miso", SPI_MISO, 0);
        dbg_chk("mrst_dbg55", 8'h55, 8'h00);
        dbg_chk("mrst_dbg10", 8'h10, 8'h00);
        for (int i = 0; i < 256; i++) mem_m[i] = 8'h00;
        exq.delete();
        srstn = 1'b1;
        tick(2);
        fd0 = fd_cnt;
        bits(20);
        csn_rise();
        chk("mrst_no_frame_done", fd_cnt - fd0, 0);
        chk("mrst_pending", exq.size(), 0);

        fill_rand();
        tx_buf[2] = 8'h77;
        do_write(8'h40, 1, 0);
        do_read(8'h40, 1);

        for (int it = 0; it < 30; it++) begin
            fill_rand();
            kind = int'($urandom_range(0, 9));
            a = 8'($urandom);
            if (kind < 4) begin
                do_write(a, int'($urandom_range(0, 4)),
                         int'($urandom_range(0, 7)));
            end else if (kind < 8) begin
                if ($urandom_range(0, 1) == 1) a = 8'($urandom_range(250, 255));
                do_read(a, int'($urandom_range(1, 3)));
            end else if (kind == 8) begin
                while (tx_buf[0] == 8'h02 || tx_buf[0] == 8'h03)
                    tx_buf[0] = 8'($urandom);
                do_raw(8 + 8 * int'($urandom_range(0, 2)), 1);
            end else begin
                do_raw(int'($urandom_range(0, 7)), 0);
            end
        end

        for (int i = 0; i < 256; i++) begin
            dbg_chk("final_mem", 8'(i), mem_m[i]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_slave_mem.md
Name: spi_slave_mem

Overview:
- SPI mode-0 slave: the downstream stage of the SPI master. It consumes SPI_SCLK, SPI_CSN and SPI_MOSI and drives SPI_MISO.
- It decodes write and read frames against an internal byte memory, so the master's wr_start/rd_start flows can be closed in co-emulation.
- All SPI inputs are oversampled in the system clock domain. There is no second clock.
- A side write-observation port and a debug read port support scoreboarding.

Parameters:
- AW, 8, address width. Memory depth = 2**AW bytes.
- CMD_WR, 8'h02, write command opcode.
- CMD_RD, 8'h03, read command opcode.

Ports:
- sclk  in  1  system clock. All logic is on the rising edge.
- srstn  in  1  asynchronous, active-low reset.
- SPI_SCLK  in  1  SPI clock from the master. CPOL=0.
- SPI_CSN  in  1  chip select, active low.
- SPI_MOSI  in  1  master data out. MSB first.
- SPI_MISO  out  1  slave data out. MSB first. Driven 0 when not in a read data phase.
- mem_we  out  1  one-cycle pulse per memory byte written.
- mem_waddr  out  AW  address of the write.
- mem_wdata  out  8  data of the write.
- frame_done  out  1  one-cycle pulse when CSN deasserts after a frame started.
- cmd_err  out  1  one-cycle pulse when an unknown opcode completes.
- dbg_addr  in  AW  debug read address.
- dbg_rdata  out  8  combinational mem[dbg_addr].

Behaviour:
- Reset:
  - All outputs are 0. State = IDLE.
  - Memory is cleared to 8'h00.
  - Sync flops reset to SCLK=0, MOSI=0, CSN=0.
  - Because CSN resets low, a frame already in progress at reset release is not entered. A new frame needs a synced CSN 1->0 edge.
- Sampling:
  - 2-flop synchronizer on each SPI input, plus one history flop for edge detect.
  - A pin edge is acted on 3 sclk cycles later.
  - Master constraint: SPI_SCLK high and low phases each >= 4 sclk periods. CSN setup/hold to the first and last SCLK edge >= 4 sclk periods.
- State machine: IDLE, CMD, ADDR, WDATA, RDATA, IGNORE.
  - IDLE -> CMD on a synced CSN falling edge. bit_cnt=0.
  - A synced CSN high in any non-IDLE state -> IDLE. Any partial byte is discarded. frame_done pulses. MISO is driven 0.
  - Every synced SCLK rising edge in CMD, ADDR or WDATA shifts MOSI into rx_sh (LSB in) and increments bit_cnt (3 bits, wraps).
  - The byte completes when bit_cnt == 7 on a rising edge.
  - CMD complete:
    - CMD_WR -> ADDR with dir = write.
    - CMD_RD -> ADDR with dir = read.
    - Any other opcode -> IGNORE, and cmd_err pulses the same cycle.
  - ADDR complete:
    - addr_ptr <= byte[AW-1:0].
    - Write: -> WDATA.
    - Read: -> RDATA. tx_sh <= mem[byte], and addr_ptr <= byte+1.
  - WDATA complete:
    - mem[addr_ptr] <= byte. addr_ptr <= addr_ptr+1, modulo 2**AW.
    - mem_we/mem_waddr/mem_wdata are valid in the same cycle as the memory write.
  - RDATA:
    - Each synced SCLK falling edge sets SPI_MISO <= tx_sh[7] and tx_sh <= tx_sh<<1.
    - Rising edges count bits (MOSI is ignored).
    - On the 8th rising edge, tx_sh <= mem[addr_ptr] and addr_ptr <= addr_ptr+1 (wrap). The next byte streams without gap.
  - IGNORE: all SCLK activity is ignored until CSN goes high.
- Timing and edge cases:
  - The first MISO bit of the first read byte appears on the falling edge that follows the 8th address rising edge. This is compliant with mode 0.
  - Back-to-back frames require CSN high for >= 4 sclk periods.
  - Debug read of an address written in the same cycle returns the old value. The new value is visible the next cycle.
  - A write frame with zero complete data bytes writes nothing and still pulses frame_done.
  - Reset mid-frame aborts immediately, clears memory, and requires a CSN edge as described under Reset.

Test Plan:
- Write 0x55: frame CSN low, bytes 02 55 AA BB CC, CSN high.
  - mem_we pulses 3 times, with (0x55,AA), (0x56,BB), (0x57,CC).
  - frame_done pulses once.
  - dbg reads of 0x55..0x57 return AA, BB, CC.
- Read back: frame 03 55, then 24 SCLKs.
  - MISO bits form AA BB CC, MSB first.
  - The first bit is valid before the first rising edge of the data phase.
  - No mem_we.
- Wrap: write 02 FE 11 22 33.
  - Writes land at FE, FF, 00.
  - Reading 03 FF for 2 bytes returns 22 33.
- Bad opcode: frame 9F 00 12.
  - cmd_err pulses once after the 8th bit.
  - No mem_we. MISO stays 0. frame_done pulses at CSN high.
- Abort: 02 10 A5, then CSN raised after 4 bits of the next byte.
  - Only mem[10]=A5 is written. The partial byte is discarded.
  - The next frame 03 10 reads A5.
- Reset mid-frame: srstn low during WDATA with CSN held low.
  - Outputs go to 0 and memory reads 00.
  - After release, the continuing SCLKs cause no writes until CSN goes high and then falls again.
